// File: rtl/pixel_sram_reader.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sram_reader
// Purpose  : Read-side master for a 1024x48 pixel SRAM. A start command sweeps
//            len consecutive words from base_addr and presents them as a
//            valid/ready pixel stream. A small output FIFO with credit-based
//            issue absorbs the 1-cycle SRAM read latency and downstream
//            backpressure while sustaining one pixel per cycle.
// Ports    : clk, rst_n                  clock / async active-low reset
//            start, base_addr, len       command strobe and arguments
//            busy, done                  command status (done = 1-cycle pulse)
//            sram_cs/oe/wen/addr, sram_do  SRAM read port
//            pix_valid, pix_ready, pix_data  output pixel stream
// Revision : 1.0  initial release
// ============================================================================
module pixel_sram_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 48,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [2:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_do,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  // Occupancy including the in-flight read can reach FIFO_DEPTH + 1.
  localparam int c_occ_w = $clog2(FIFO_DEPTH + 2);

  localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_occ_w-1:0] c_depth_occ = c_occ_w'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]    c_cnt_one   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_ZERO  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_issued;
  logic [ADDR_W:0]     r_accepted;
  logic                r_inflight;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_cnt;

  logic                w_pop;
  logic                w_push;
  logic [c_occ_w-1:0]  w_occ;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_last_pop;

  // ---------------------------------------------------------------------------
  // Issue control. The credit check counts the word already in flight and
  // credits back a slot being popped this same cycle, so a full FIFO that is
  // draining still allows back-to-back reads.
  // ---------------------------------------------------------------------------
  assign w_pop  = pix_valid & pix_ready;
  assign w_push = r_inflight;
  assign w_occ  = c_occ_w'(r_cnt) + c_occ_w'(r_inflight) - c_occ_w'(w_pop);

  assign w_issue      = (r_state == S_READ) && (r_issued < r_len) && (w_occ < c_depth_occ);
  assign w_last_issue = w_issue && ((r_issued + c_cnt_one) == r_len);
  assign w_last_pop   = w_pop && ((r_accepted + c_cnt_one) == r_len);

  assign sram_cs   = w_issue;
  assign sram_oe   = r_busy;
  assign sram_wen  = 3'b111;
  // Address arithmetic is ADDR_W wide so the sweep wraps from the top word to 0.
  assign sram_addr = r_base + r_issued[ADDR_W-1:0];

  assign busy      = r_busy;
  // done must coincide with the final handshake, so it is decoded from the
  // registered state plus the live handshake rather than registered itself.
  assign done      = (r_state == S_ZERO) || ((r_state == S_DRAIN) && w_last_pop);

  assign pix_valid = (r_cnt != '0);
  assign pix_data  = r_mem[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // Command FSM and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;

      if (w_pop) begin
        r_accepted <= r_accepted + c_cnt_one;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_len      <= len;
            r_issued   <= '0;
            r_accepted <= '0;
            r_busy     <= 1'b1;
            r_state    <= (len == '0) ? S_ZERO : S_READ;
          end
        end
        S_ZERO: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_READ: begin
          if (w_issue) begin
            r_issued <= r_issued + c_cnt_one;
            if (w_last_issue) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. Push is the registered chip select (SRAM data is valid the
  // cycle after the read) and happens regardless of downstream readiness;
  // the issue credit check guarantees a free slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= sram_do;
        r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
      end
      r_cnt <= r_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_sram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sram_reader
// Purpose  : Self-checking bench for pixel_sram_reader. Commands push their
//            expected addresses and pixels into queues; a negedge monitor
//            pops and compares whenever the DUT reads or hands off a pixel.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_sram_reader;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 48;
  localparam int DEPTH   = 4;
  localparam int WORDS   = 1024;
  localparam int INT_MAX = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy, done, sram_cs, sram_oe, pix_valid;
  logic [2:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_do = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready = 1'b1;

  pixel_sram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_cs(sram_cs), .sram_oe(sram_oe),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_do(sram_do),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read, lanes hold the word index.
  logic [DATA_W-1:0] mem [WORDS];
  initial for (int i = 0; i < WORDS; i++) mem[i] = {3{16'(i)}};
  always @(posedge clk) if (sram_cs) sram_do <= mem[sram_addr];

  // Reference model: the word at address a is {a,a,a} in 16-bit lanes.
  function automatic logic [DATA_W-1:0] exp_pix(int a);
    return {3{16'(a % WORDS)}};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Scoreboard state shared by driver and monitor.
  logic [ADDR_W-1:0] aq[$];
  logic [DATA_W-1:0] dq[$];
  int busy_from = INT_MAX;
  int busy_to   = -1;
  int zero_due  = -1;
  int last_done_cyc = -1;
  int n_pop = 0;

  // Downstream ready generator.
  int         ready_mode = 0;   // 0: always, 1: fixed pattern, 2: random
  int         pidx = 0;
  logic [7:0] pat = 8'b0110_1001; // 1,0,0,1,0,1,1,0 from bit 0 upwards
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: begin pix_ready = pat[pidx]; pidx = (pidx + 1) % 8; end
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  int                m_occ = 0;
  int                m_infl = 0;
  logic              m_hs, m_fin, m_exp_busy, m_prev_stall = 1'b0;
  logic [DATA_W-1:0] m_prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_occ = 0; m_infl = 0; m_prev_stall = 1'b0;
    end else begin
      m_hs  = pix_valid & pix_ready;
      m_fin = 1'b0;
      if (sram_cs) begin
        chk("sram_wen", 64'(sram_wen), 64'(3'b111));
        if (aq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_read: got addr %0d expected no read (cycle %0d)", sram_addr, cyc);
        end else begin
          chk("sram_addr", 64'(sram_addr), 64'(aq.pop_front()));
        end
      end
      if (m_hs) begin
        n_pop++;
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pixel: got %0h expected none (cycle %0d)", pix_data, cyc);
        end else begin
          chk("pix_data", 64'(pix_data), 64'(dq.pop_front()));
          if (dq.size() == 0) begin
            m_fin   = 1'b1;
            busy_to = cyc;
          end
        end
      end
      m_exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      chk("busy", 64'(busy), 64'(m_exp_busy));
      chk("sram_oe", 64'(sram_oe), 64'(m_exp_busy));
      chk("done", 64'(done), 64'(m_fin || (cyc == zero_due)));
      if (done) last_done_cyc = cyc;
      chk("pix_valid", 64'(pix_valid), 64'(m_occ != 0));
      chk("fifo_bound", 64'((m_occ + m_infl - int'(m_hs) + int'(sram_cs)) <= DEPTH), 64'(1));
      if (m_prev_stall) begin
        chk("hold_valid", 64'(pix_valid), 64'(1));
        chk("hold_data", 64'(pix_data), 64'(m_prev_data));
      end
      m_prev_stall = pix_valid & ~pix_ready;
      m_prev_data  = pix_data;
      m_occ  = m_occ + m_infl - int'(m_hs);
      m_infl = int'(sram_cs);
    end
  end

  // Driver tasks (operate at posedge + #1).
  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (!(dq.size() == 0 && cyc > busy_to && cyc > zero_due)) begin
      @(posedge clk); #1;
      n++;
      if (n > 4000) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_idle: got %0d pixels outstanding expected 0 after %0d cycles", dq.size(), n);
        summary_and_finish();
      end
    end
  endtask

  task automatic run_cmd(int b, int l, output int c);
    wait_idle();
    start = 1'b1; base_addr = ADDR_W'(b); len = (ADDR_W+1)'(l);
    c = cyc;
    busy_from = c + 1;
    if (l == 0) begin
      busy_to = c + 1; zero_due = c + 1;
    end else begin
      busy_to = INT_MAX;
      for (int k = 0; k < l; k++) begin
        aq.push_back(ADDR_W'((b + k) % WORDS));
        dq.push_back(exp_pix(b + k));
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    len = (ADDR_W+1)'($urandom);
  endtask

  task automatic cmd(int b, int l);
    int c;
    run_cmd(b, l, c);
    wait_idle();
    if (ready_mode == 0 && l > 0) chk("done_latency", 64'(last_done_cyc - c), 64'(l + 2));
  endtask

  task automatic chk_reset(string name);
    chk(name, 64'({busy, done, sram_cs, sram_oe, pix_valid, sram_wen, sram_addr}),
        64'({5'b0, 3'b111, 10'd0}));
    chk({name, "_data"}, 64'(pix_data), 64'(0));
  endtask

  initial begin
    int c, p0, n;
    // Initial reset
    @(negedge clk);
    chk_reset("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: len 4, full throughput, cycle-exact profile
    ready_mode = 0;
    run_cmd(0, 4, c);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("profile_c%0d", k), 64'({sram_cs, pix_valid, done, busy}),
          64'({(k >= 1 && k <= 4), (k >= 3 && k <= 6), (k == 6), (k >= 1 && k <= 6)}));
    end
    wait_idle();
    chk("t1_latency", 64'(last_done_cyc - c), 64'(6));

    // 2: len 8 with fixed ready pattern
    ready_mode = 1; pidx = 0;
    cmd(0, 8);

    // 3: address wrap
    ready_mode = 0;
    cmd(1022, 4);

    // 4: zero-length command
    cmd(7, 0);

    // 5a: start while busy is ignored
    ready_mode = 2;
    run_cmd(20, 8, c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd100; len = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // 5b: reset in the middle of a command
    ready_mode = 0;
    p0 = n_pop;
    run_cmd(0, 8, c);
    n = 0;
    while (n_pop < p0 + 3 && n < 100) begin
      @(posedge clk); n++;
    end
    chk("reset_at_pixel3", 64'(n_pop - p0), 64'(3));
    #2 rst_n = 1'b0;
    #1 chk_reset("midcmd_reset");
    aq.delete(); dq.delete();
    busy_to = -1; zero_due = -1; busy_from = INT_MAX;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmd(5, 2);

    // 6: full memory sweep
    cmd(0, 1024);

    // Randomized commands
    for (int t = 0; t < 30; t++) begin
      ready_mode = (t % 3 == 0) ? 0 : 2;
      cmd(int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, 12)));
    end

    summary_and_finish();
  end

  initial begin
    #2_000_000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    summary_and_finish();
  end

endmodule
`default_nettype wire
